// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 keystroke sequencer.
package ps2_pkg;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam int         KEY_W   = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ORPHAN,
        ST_MAKE,
        ST_BREAK,
        ST_HOLDOFF
    } ps2_state_t;

endpackage

// File: rtl/ps2_key_fifo.sv
// First-word fall-through keystroke queue; head is visible one cycle after push.
module ps2_key_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keystroke_sequencer.sv
// Decodes PS/2 make/break/E0 byte streams into keystrokes and queues them for the consumer.
module ps2_keystroke_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int HOLDOFF_CYCLES = 5000,
    parameter int EMIT_ON_BREAK  = 1,
    parameter int REPEAT_EN      = 0,
    parameter int EXT_EN         = 1
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic [7:0]       received_data,
    input  logic             received_data_en,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             rotate,
    output logic             overflow,
    input  logic             overflow_clr,
    output logic [7:0]       drop_count,
    output logic             busy
);

    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    ps2_state_t       state;
    logic [KEY_W-1:0] held;
    logic             ext;
    logic [HW-1:0]    hold_cnt;

    logic             is_e0, is_f0;
    logic [KEY_W-1:0] cur;
    logic             push, push_ok, pop, fifo_full, fifo_empty;
    logic [KEY_W-1:0] push_data;

    assign is_e0     = (received_data == BYTE_E0);
    assign is_f0     = (received_data == BYTE_F0);
    assign cur       = {ext, received_data};
    assign pop       = key_valid && key_ready;
    assign push_ok   = push && (!fifo_full || pop);
    assign key_valid = !fifo_empty;
    assign busy      = (state != ST_IDLE);

    // Emit decision is combinational so the push lands in the same cycle as the byte.
    always_comb begin
        push      = 1'b0;
        push_data = held;
        if (received_data_en) begin
            case (state)
                ST_IDLE: if (!is_e0 && !is_f0) begin
                    push      = (EMIT_ON_BREAK == 0);
                    push_data = cur;
                end
                ST_MAKE: if (!is_e0 && !is_f0 && cur == held)
                    push = (REPEAT_EN != 0) && (EMIT_ON_BREAK == 0);
                ST_BREAK: if (!is_e0 && cur == held)
                    push = (EMIT_ON_BREAK != 0);
                default: push = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            held       <= '0;
            ext        <= 1'b0;
            hold_cnt   <= '0;
            drop_count <= '0;
            rotate     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rotate <= push_ok;
            if (overflow_clr)           overflow <= 1'b0;
            else if (push && !push_ok)  overflow <= 1'b1;

            case (state)
                ST_IDLE: if (received_data_en) begin
                    if (is_e0) begin
                        if (EXT_EN != 0) ext <= 1'b1;
                    end else if (is_f0) begin
                        state <= ST_ORPHAN;
                    end else begin
                        held  <= cur;
                        ext   <= 1'b0;
                        state <= ST_MAKE;
                    end
                end
                // Release of a key we never saw pressed: swallow its code.
                ST_ORPHAN: if (received_data_en) begin
                    ext   <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_MAKE: if (received_data_en) begin
                    if (is_e0) begin
                        if (EXT_EN != 0) ext <= 1'b1;
                    end else if (is_f0) begin
                        state <= ST_BREAK;
                    end else begin
                        ext <= 1'b0;
                    end
                end
                ST_BREAK: if (received_data_en && !is_e0) begin
                    ext <= 1'b0;
                    if (cur == held) begin
                        hold_cnt <= '0;
                        if (HOLDOFF_CYCLES == 0) state <= ST_IDLE;
                        else                     state <= ST_HOLDOFF;
                    end else begin
                        state <= ST_MAKE;
                    end
                end
                ST_HOLDOFF: begin
                    if (received_data_en && drop_count != 8'hFF)
                        drop_count <= drop_count + 8'd1;
                    if (hold_cnt == HW'(HOLDOFF_CYCLES - 1)) begin
                        hold_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ps2_key_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLOCK_50),
        .rst_n    (reset_n),
        .push     (push),
        .data_in  (push_data),
        .full     (fifo_full),
        .pop      (pop),
        .data_out (key_code),
        .empty    (fifo_empty)
    );

endmodule

// File: doc/ps2_keystroke_sequencer.md
Name: ps2_keystroke_sequencer

Overview:
Parametrised successor to the inline make/break/wait keyboard FSM in the Enigma top level. It consumes PS/2 bytes from PS2_Controller and decodes make, break and E0-extended sequences, with optional typematic repeat. Completed keystrokes are queued in a small FIFO and presented to State_Machine and the display path over a valid/ready handshake, alongside a one-cycle rotate strobe.

Parameters:
FIFO_DEPTH, 4, keystroke queue entries; power of 2, at least 2.
HOLDOFF_CYCLES, 5000, post-release dead time in clocks; 0 skips the HOLDOFF state.
EMIT_ON_BREAK, 1, 1 = emit keystroke on matching release; 0 = emit on make.
REPEAT_EN, 0, when EMIT_ON_BREAK=0, a repeated make code of the held key emits again.
EXT_EN, 1, 1 = decode E0 prefix into key_code[8]; 0 = drop E0 bytes.

Ports:
CLOCK_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
received_data  in  8  PS/2 byte from PS2_Controller
received_data_en  in  1  byte strobe, one cycle per byte
key_code  out  9  FIFO head: [8] extended flag, [7:0] scan code
key_valid  out  1  FIFO non-empty
key_ready  in  1  consumer accepts head
rotate  out  1  one-cycle pulse per keystroke accepted into the FIFO
overflow  out  1  sticky: a keystroke was dropped because the FIFO was full
overflow_clr  in  1  synchronous clear of overflow
drop_count  out  8  saturating count of bytes ignored during HOLDOFF
busy  out  1  FSM state is not IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, FIFO empty, key_valid=0, key_code=0, rotate=0, overflow=0, drop_count=0, held-key register=0, ext flag=0, holdoff counter=0.
- Bytes are processed only when received_data_en=1. Constants: E0=8'hE0, F0=8'hF0.
- IDLE:
  - E0 (when EXT_EN) sets ext and the FSM stays in IDLE.
  - F0 goes to ORPHAN; the next byte is discarded, then IDLE.
  - Any other byte latches held={ext,byte}, clears ext, goes to MAKE, and emits when EMIT_ON_BREAK=0.
- MAKE:
  - E0 sets ext.
  - F0 goes to BREAK.
  - A byte equal to held with ext matching is a typematic repeat: emit if REPEAT_EN and EMIT_ON_BREAK=0, clear ext.
  - Any other code is ignored (no rollover) and clears ext.
- BREAK:
  - A byte with {ext,byte}==held releases the key: emit if EMIT_ON_BREAK=1, clear ext, go to HOLDOFF (or IDLE if HOLDOFF_CYCLES=0).
  - E0 in BREAK is ignored.
  - A mismatched code clears ext and returns to MAKE; the FSM must never stall.
- HOLDOFF: counter runs 0..HOLDOFF_CYCLES-1, then IDLE. Each byte strobe during HOLDOFF increments drop_count, saturating at 255.
- Emit means push held into the FIFO in the same cycle; rotate=1 on the next cycle only if the push was accepted.
- FIFO is first-word fall-through:
  - key_code is valid the cycle after the push (push-to-valid latency 1).
  - Pop occurs when key_valid && key_ready.
  - Push into a full FIFO with no pop in that cycle: entry discarded, overflow<=1, no rotate.
  - Push into a full FIFO with a simultaneous pop: push accepted, occupancy unchanged.
  - Push into an empty FIFO with key_ready=1: data appears next cycle; no bypass.
- overflow_clr has priority under a simultaneous set: overflow ends at 0 and the drop is lost silently.
- key_code holds its value when the FIFO is empty (don't-care for consumers; bench checks only when valid).
- Asserting reset mid-sequence or mid-HOLDOFF discards all FIFO contents and partial sequences.

Decomposition:
- Shared package ps2_pkg: E0/F0 byte constants, FSM state encoding (IDLE, ORPHAN, MAKE, BREAK, HOLDOFF), key_code width (9).
- Sub-module ps2_key_fifo (params WIDTH, DEPTH; ports push/data_in/full, pop/data_out/empty). The sequencer instantiates it once and owns the overflow logic.

Test Plan:
1. Defaults: bytes 1C, F0, 1C with key_ready=1 -> single entry key_code=9'h01C; rotate pulses once; busy stays high 5000 cycles after the release, then 0.
2. Extended key: E0 75, E0 F0 75 -> key_code=9'h175. Sequence E0 75, F0 75 -> no emit (ext mismatch), FSM back in MAKE.
3. EMIT_ON_BREAK=0, REPEAT_EN=1, HOLDOFF_CYCLES=0: 1C 1C 1C F0 1C -> three entries 9'h01C, three rotate pulses, FSM in IDLE.
4. Overflow: key_ready=0, FIFO_DEPTH=4, five complete keystrokes 15,1D,24,2D,2C -> FIFO holds 15,1D,24,2D; overflow=1; 4 rotate pulses. Then overflow_clr -> overflow=0, and draining yields entries in order.
5. Holdoff drops: 3 bytes sent within 5000 cycles of a release -> drop_count=3, no entries. Stray F0 1C from IDLE -> nothing emitted.
6. Reset mid-sequence: 1C F0, then reset_n low for 1 cycle -> all outputs at reset values. Then 1C F0 1C -> normal single emit of 9'h01C.
